// File: rtl/bus_addr_router.sv
// bus_addr_router: registered address decoder and transaction router between
// the CPU data port and N_SLAVES memory-mapped slaves.
//
// Each slot i owns the window [REGION_BASE[i], REGION_LIMIT[i]). A slot with
// limit 0 is disabled. When windows overlap, the lowest slot index wins.
// Unmapped addresses and slaves that stay silent for TIMEOUT_CYCLES access
// cycles complete with an error response.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_req/i_we/i_addr/    master request, sampled only in IDLE
//   i_wdata/i_be
//   o_ack/o_err/o_rdata   one-cycle completion, error flag, read data
//   o_slave_DV            one-hot slave select
//   o_slave_addr/we/      request fields latched at acceptance
//   wdata/be
//   i_slave_ack           per-slave completion
//   i_slave_rdata         per-slave read data, slot i at [i*DATA_W +: DATA_W]
//
// Optional feature, macro ROUTER_ERR_LOG_EN: adds o_err_addr (address of the
// last error response) and o_err_count (saturating error count).

module bus_addr_router_slot #(
  parameter int               ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE  = '0,
  parameter logic [ADDR_W-1:0] LIMIT = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit
);
  assign hit = (LIMIT != '0) && (addr >= BASE) && (addr < LIMIT);
endmodule

module bus_addr_router #(
  parameter int N_SLAVES       = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [N_SLAVES*ADDR_W-1:0] REGION_BASE =
    {32'h50000000, 32'h40000000, 32'h30000000, 32'h10000000},
  parameter logic [N_SLAVES*ADDR_W-1:0] REGION_LIMIT =
    {32'h60000000, 32'h50000000, 32'h40000000, 32'h10000006}
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_req,
  input  logic                       i_we,
  input  logic [ADDR_W-1:0]          i_addr,
  input  logic [DATA_W-1:0]          i_wdata,
  input  logic [DATA_W/8-1:0]        i_be,
  output logic                       o_ack,
  output logic                       o_err,
  output logic [DATA_W-1:0]          o_rdata,
  output logic [N_SLAVES-1:0]        o_slave_DV,
  output logic [ADDR_W-1:0]          o_slave_addr,
  output logic                       o_slave_we,
  output logic [DATA_W-1:0]          o_slave_wdata,
  output logic [DATA_W/8-1:0]        o_slave_be,
  input  logic [N_SLAVES-1:0]        i_slave_ack,
  input  logic [N_SLAVES*DATA_W-1:0] i_slave_rdata
`ifdef ROUTER_ERR_LOG_EN
  ,
  output logic [ADDR_W-1:0]          o_err_addr,
  output logic [7:0]                 o_err_count
`endif
);

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ACCESS, S_RESP} state_t;

  state_t              state;
  logic [N_SLAVES-1:0] raw_hit, hit_first, hit_q;
  logic [15:0]         timer;
  logic                sel_ack, timeout, err_event;
  logic [DATA_W-1:0]   sel_rdata;

  for (genvar g = 0; g < N_SLAVES; g++) begin : g_slot
    bus_addr_router_slot #(
      .ADDR_W (ADDR_W),
      .BASE   (REGION_BASE[g*ADDR_W +: ADDR_W]),
      .LIMIT  (REGION_LIMIT[g*ADDR_W +: ADDR_W])
    ) u_slot (
      .addr (i_addr),
      .hit  (raw_hit[g])
    );
  end

  // Isolate the lowest set bit so overlapping windows resolve to one slot.
  assign hit_first = raw_hit & (~raw_hit + N_SLAVES'(1));

  // o_slave_DV is one-hot in ACCESS, so it gates both ack and read data.
  assign sel_ack = |(i_slave_ack & o_slave_DV);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++)
      if (o_slave_DV[i]) sel_rdata = sel_rdata | i_slave_rdata[i*DATA_W +: DATA_W];
  end

  // A same-cycle ack beats the timeout.
  assign timeout   = (state == S_ACCESS) && !sel_ack && (timer == TIMER_LAST);
  assign err_event = ((state == S_DECODE) && (hit_q == '0)) || timeout;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= S_IDLE;
      hit_q         <= '0;
      timer         <= '0;
      o_ack         <= 1'b0;
      o_err         <= 1'b0;
      o_rdata       <= '0;
      o_slave_DV    <= '0;
      o_slave_addr  <= '0;
      o_slave_we    <= 1'b0;
      o_slave_wdata <= '0;
      o_slave_be    <= '0;
    end else begin
      o_ack <= 1'b0;
      o_err <= 1'b0;
      case (state)
        S_IDLE: if (i_req) begin
          o_slave_addr  <= i_addr;
          o_slave_we    <= i_we;
          o_slave_wdata <= i_wdata;
          o_slave_be    <= i_be;
          hit_q         <= hit_first;
          state         <= S_DECODE;
        end
        S_DECODE: if (hit_q == '0) begin
          o_ack   <= 1'b1;
          o_err   <= 1'b1;
          o_rdata <= '0;
          state   <= S_RESP;
        end else begin
          o_slave_DV <= hit_q;
          state      <= S_ACCESS;
        end
        S_ACCESS: if (sel_ack) begin
          o_ack      <= 1'b1;
          o_rdata    <= o_slave_we ? '0 : sel_rdata;
          o_slave_DV <= '0;
          timer      <= '0;
          state      <= S_RESP;
        end else if (timeout) begin
          o_ack      <= 1'b1;
          o_err      <= 1'b1;
          o_rdata    <= '0;
          o_slave_DV <= '0;
          timer      <= '0;
          state      <= S_RESP;
        end else begin
          timer <= timer + 16'd1;
        end
        S_RESP: begin
          timer <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ROUTER_ERR_LOG_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_err_addr  <= '0;
      o_err_count <= '0;
    end else if (err_event) begin
      o_err_addr <= o_slave_addr;
      if (o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
    end
  end
`else
  logic unused_err_event;
  assign unused_err_event = err_event;
`endif

endmodule

// File: tb/tb_bus_addr_router.sv
// Self-checking bench for bus_addr_router. Two instances share the request
// inputs: dut (TIMEOUT_CYCLES=255, driven by a scripted slave) and dut_t4
// (TIMEOUT_CYCLES=4, slaves never ack). Inputs change and outputs are
// sampled on the falling edge; "cycle 0" is the cycle the request is driven.
module tb_bus_addr_router;

  localparam int TO_MAIN = 255;
  localparam int TO_T4   = 4;

  logic         clk = 1'b0;
  logic         reset, req, we;
  logic [31:0]  addr, wdata;
  logic [3:0]   be;
  logic         ack, err, s_we;
  logic [31:0]  rdata, s_addr, s_wdata;
  logic [3:0]   dv, s_be, s_ack;
  logic [127:0] s_rdata;
  logic         t4_ack, t4_err, t4_s_we;
  logic [31:0]  t4_rdata, t4_s_addr, t4_s_wdata;
  logic [3:0]   t4_dv, t4_s_be;
  logic [3:0]   zero_ack = 4'b0;
`ifdef ROUTER_ERR_LOG_EN
  logic [31:0]  err_addr, t4_err_addr;
  logic [7:0]   err_cnt, t4_err_cnt;
  int           m_cnt = 0;
  logic [31:0]  m_eaddr = '0;
`endif

  int          n_cmp = 0, n_bad = 0;
  logic [31:0] prev_rd = '0;

  always #5 clk = ~clk;

  bus_addr_router dut (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .i_be(be), .o_ack(ack), .o_err(err), .o_rdata(rdata),
    .o_slave_DV(dv), .o_slave_addr(s_addr), .o_slave_we(s_we),
    .o_slave_wdata(s_wdata), .o_slave_be(s_be), .i_slave_ack(s_ack),
    .i_slave_rdata(s_rdata)
`ifdef ROUTER_ERR_LOG_EN
    , .o_err_addr(err_addr), .o_err_count(err_cnt)
`endif
  );

  bus_addr_router #(.TIMEOUT_CYCLES(TO_T4)) dut_t4 (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .i_be(be), .o_ack(t4_ack), .o_err(t4_err), .o_rdata(t4_rdata),
    .o_slave_DV(t4_dv), .o_slave_addr(t4_s_addr), .o_slave_we(t4_s_we),
    .o_slave_wdata(t4_s_wdata), .o_slave_be(t4_s_be), .i_slave_ack(zero_ack),
    .i_slave_rdata(s_rdata)
`ifdef ROUTER_ERR_LOG_EN
    , .o_err_addr(t4_err_addr), .o_err_count(t4_err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode: first enabled window containing the address, -1 if none.
  function automatic int model_slot(input logic [31:0] a);
    logic [31:0] b [4];
    logic [31:0] l [4];
    b = '{32'h10000000, 32'h30000000, 32'h40000000, 32'h50000000};
    l = '{32'h10000006, 32'h40000000, 32'h50000000, 32'h60000000};
    for (int i = 0; i < 4; i++)
      if (l[i] != 0 && a >= b[i] && a < l[i]) return i;
    return -1;
  endfunction

  // One transaction on dut; the selected slave acks in ACCESS cycle number
  // `delay` (0 = first). With chk_t4, dut_t4 (assumed idle) is checked too.
  task automatic run_txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                         input logic [3:0] t_be, input int delay, input logic [31:0] rd_val,
                         input bit chk_t4);
    int          slot, ack_cyc, t4_cyc, last;
    bit          exp_err;
    logic [3:0]  oh;
    logic [31:0] exp_rd, rd_now;
    slot    = model_slot(t_addr);
    exp_err = (slot < 0) || (delay >= TO_MAIN);
    ack_cyc = (slot < 0) ? 2 : ((delay < TO_MAIN) ? 3 + delay : 2 + TO_MAIN);
    t4_cyc  = (slot < 0) ? 2 : 2 + TO_T4;
    oh      = (slot < 0) ? 4'b0 : 4'(1 << slot);
    exp_rd  = (exp_err || t_we) ? 32'h0 : rd_val;
    last    = (chk_t4 && t4_cyc > ack_cyc) ? t4_cyc : ack_cyc;
`ifdef ROUTER_ERR_LOG_EN
    if (exp_err) begin
      if (m_cnt < 255) m_cnt++;
      m_eaddr = t_addr;
    end
`endif
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; be = t_be;
    for (int c = 0; c <= last; c++) begin
      rd_now = (c < ack_cyc) ? prev_rd : exp_rd;
      chk("dv", dv, (slot >= 0 && c >= 2 && c < ack_cyc) ? oh : 4'b0);
      chk("ack", ack, c == ack_cyc);
      chk("rdata", rdata, rd_now);
      if (c == 1) begin
        chk("slave_addr", s_addr, t_addr);
        chk("slave_we", s_we, t_we);
        chk("slave_wdata", s_wdata, t_wdata);
        chk("slave_be", s_be, t_be);
      end
      if (c == ack_cyc) chk("err", err, exp_err);
`ifdef ROUTER_ERR_LOG_EN
      if (c == ack_cyc) begin
        chk("err_count", err_cnt, m_cnt);
        chk("err_addr", err_addr, m_eaddr);
      end
`endif
      if (chk_t4) begin
        chk("t4_dv", t4_dv, (slot >= 0 && c >= 2 && c < t4_cyc) ? oh : 4'b0);
        chk("t4_ack", t4_ack, c == t4_cyc);
        if (c == t4_cyc) begin
          chk("t4_err", t4_err, 1'b1);
          chk("t4_rdata", t4_rdata, 32'h0);
        end
      end
      // Drive the next cycle: request fields scrambled after acceptance,
      // stray i_req while busy, ack noise on non-selected slots.
      if (c >= 1) begin
        addr = $urandom; wdata = $urandom; be = 4'($urandom); we = 1'($urandom);
        req  = (!chk_t4 && c < ack_cyc) ? 1'($urandom) : 1'b0;
      end
      s_ack = 4'($urandom) & ~oh;
      for (int i = 0; i < 4; i++) s_rdata[i*32 +: 32] = $urandom;
      if (slot >= 0 && c == 1 + delay + 1) begin
        s_ack[slot] = 1'b1;
        s_rdata[slot*32 +: 32] = rd_val;
      end
      @(negedge clk);
    end
    req = 1'b0; s_ack = '0;
    prev_rd = exp_rd;
  endtask

  initial begin
    logic [31:0] a;
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    s_ack = '0; s_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_dv", dv, 4'b0);
    chk("rst_saddr", s_addr, 32'h0);
    chk("rst_swe", s_we, 1'b0);
    chk("rst_swdata", s_wdata, 32'h0);
    chk("rst_sbe", s_be, 4'b0);
`ifdef ROUTER_ERR_LOG_EN
    chk("rst_err_count", err_cnt, 8'd0);
    chk("rst_err_addr", err_addr, 32'h0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    run_txn(1'b0, 32'h40000010, 32'h0, 4'hF, 0, 32'hCAFEF00D, 1'b0);
    run_txn(1'b1, 32'h10000005, 32'hAB, 4'b0001, 4, 32'h12345678, 1'b0);
    run_txn(1'b0, 32'h10000006, 32'h0, 4'hF, 0, 32'h11111111, 1'b0);
    run_txn(1'b0, 32'h00000000, 32'h0, 4'hF, 0, 32'h22222222, 1'b0);
    run_txn(1'b0, 32'h5FFFFFFF, 32'h0, 4'hF, 1, 32'h33333333, 1'b0);

    // Quiet gap so dut_t4 is idle, then timeout on both instances.
    repeat (10) @(negedge clk);
    run_txn(1'b0, 32'h30000000, 32'h0, 4'hF, 300, 32'h44444444, 1'b1);

    // Reset in the middle of an access: dropped, no ack, DV released.
    req = 1'b1; we = 1'b0; addr = 32'h40000020; be = 4'hF;
    @(negedge clk); req = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("pre_rst_dv", dv, 4'b0100);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_dv", dv, 4'b0);
    chk("mid_rst_ack", ack, 1'b0);
    chk("mid_rst_rdata", rdata, 32'h0);
    reset = 1'b0;
    prev_rd = '0;
`ifdef ROUTER_ERR_LOG_EN
    m_cnt = 0; m_eaddr = '0;
`endif
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_ack", ack, 1'b0);
      chk("post_rst_dv", dv, 4'b0);
    end
    run_txn(1'b0, 32'h50000000, 32'h0, 4'hF, 2, 32'h55AA55AA, 1'b0);

    // Random back-to-back traffic
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0:       a = 32'h10000000 + 32'($urandom_range(0, 7));
        1:       a = 32'h30000000 | ($urandom & 32'h0FFFFFFF);
        2:       a = 32'h40000000 | ($urandom & 32'h0FFFFFFF);
        3:       a = 32'h50000000 | ($urandom & 32'h0FFFFFFF);
        4:       a = 32'h5FFFFFFE + 32'($urandom_range(0, 3));
        default: a = $urandom;
      endcase
      run_txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 6), $urandom, 1'b0);
    end

`ifdef ROUTER_ERR_LOG_EN
    // Error log: fresh count, then saturation.
    reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
    m_cnt = 0; m_eaddr = '0; prev_rd = '0;
    run_txn(1'b0, 32'h00000010, 32'h0, 4'hF, 0, 32'h0, 1'b0);
    run_txn(1'b0, 32'h20000000, 32'h0, 4'hF, 0, 32'h0, 1'b0);
    run_txn(1'b0, 32'h70000000, 32'h0, 4'hF, 0, 32'h0, 1'b0);
    chk("log3_count", err_cnt, 8'd3);
    chk("log3_addr", err_addr, 32'h70000000);
    for (int n = 0; n < 297; n++)
      run_txn(1'b0, 32'h60000000 + 32'(n), 32'h0, 4'hF, 0, 32'h0, 1'b0);
    chk("log_sat_count", err_cnt, 8'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
